ctrl_fsm: RTL

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/riscv_ctrl_pkg.sv | 33 +++
 rtl/rtype_decoder.sv | 41 ++++
 rtl/ctrl_fsm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32 R-type control FSM: state encoding,
// opcode constant, ALU operation codes and result-mux select values.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    MULWAIT = 3'd4,
    WB      = 3'd5,
    TRAP    = 3'd6
  } state_t;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  // ALU operation codes, laid out as {instr[30], func3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // ifuresmux select values
  localparam int IFURES_ALU = 0;
  localparam int IFURES_MU  = 1;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: classifies the instruction fields into
// ALU-class, MUL-class or illegal and produces the unit operation codes.
// Build option: define RV32M_EN to decode the multiply group (func7b50=01);
// without it that group is reported illegal and mulctl stays 0.
module rtype_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [1:0] func7b50,
  output logic       alu_class,
  output logic       mul_class,
  output logic       illegal,
  output logic [3:0] aluctl,
  output logic [1:0] mulctl
);

  // Classify the fields; anything not positively recognised is illegal
  always_comb begin
    alu_class = 1'b0;
    mul_class = 1'b0;
    aluctl    = ALU_ADD;
    mulctl    = 2'b00;
    if (opcode == OPC_RTYPE) begin
      case (func7b50)
        2'b00: alu_class = 1'b1;
        // only SUB and SRA use instr[30]
        2'b10: alu_class = (func3 == 3'b000) || (func3 == 3'b101);
`ifdef RV32M_EN
        // func3[2]=1 is the divide group, which has no unit yet
        2'b01: mul_class = ~func3[2];
`endif
        default: ;
      endcase
    end
    if (alu_class) aluctl = {func7b50[1], func3};
    if (mul_class) mulctl = func3[1:0];
    illegal = ~(alu_class | mul_class);
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM for RV32 R-type instructions:
// IDLE -> FETCH -> DECODE -> EXEC/MULWAIT -> WB, with TRAP on illegal decode.
// Outputs are Moore, decoded from state plus the fields captured in DECODE.
// Build option: RV32M_EN enables the multiply path (MULWAIT, mulctl, ifuresctl=1).
module ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int pcmux_N     = 2,
  parameter int ifuresctl_N = 2,
  parameter int MUL_LAT     = 2
)
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     func3,
  input  logic [1:0]                     func7b50,
  output logic [$clog2(pcmux_N)-1:0]     pcmuxctl,
  output logic                           pcnextctl,
  output logic                           instrre,
  output logic                           regre,
  output logic                           regwe,
  output logic [3:0]                     aluctl,
  output logic [1:0]                     mulctl,
  output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
  output logic                           retire,
  output logic                           illegal
);

  localparam int IW = $clog2(ifuresctl_N);

  state_t     state_reg, state_next;
  logic [6:0] opcode_reg;
  logic [2:0] func3_reg;
  logic [1:0] func7b50_reg;
  logic [3:0] count_reg;
  logic       illegal_reg;

  logic [6:0] dec_opcode;
  logic [2:0] dec_func3;
  logic [1:0] dec_func7b50;
  logic       dec_alu, dec_mul, dec_illegal;
  logic [3:0] dec_aluctl;
  logic [1:0] dec_mulctl;

  // In DECODE the live fields steer the branch; afterwards the captured
  // copy keeps the operation codes stable while the datapath input moves on.
  assign dec_opcode   = (state_reg == DECODE) ? opcode   : opcode_reg;
  assign dec_func3    = (state_reg == DECODE) ? func3    : func3_reg;
  assign dec_func7b50 = (state_reg == DECODE) ? func7b50 : func7b50_reg;

  rtype_decoder u_dec (
    .opcode    (dec_opcode),
    .func3     (dec_func3),
    .func7b50  (dec_func7b50),
    .alu_class (dec_alu),
    .mul_class (dec_mul),
    .illegal   (dec_illegal),
    .aluctl    (dec_aluctl),
    .mulctl    (dec_mulctl)
  );

  // State register, field capture, multiply latency counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      opcode_reg   <= '0;
      func3_reg    <= '0;
      func7b50_reg <= '0;
      count_reg    <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE) begin
        opcode_reg   <= opcode;
        func3_reg    <= func3;
        func7b50_reg <= func7b50;
        // counting down to 0 keeps MULWAIT exactly MUL_LAT cycles
        count_reg    <= 4'(MUL_LAT - 1);
        if (dec_illegal) illegal_reg <= 1'b1;
      end else if ((state_reg == MULWAIT) && (count_reg != 4'd0)) begin
        count_reg <= count_reg - 4'd1;
      end
    end
  end

  // Next-state logic; run only matters in IDLE and WB
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (run) state_next = FETCH;
      FETCH:   state_next = DECODE;
      DECODE:  state_next = dec_alu ? EXEC : (dec_mul ? MULWAIT : TRAP);
      EXEC:    state_next = WB;
      MULWAIT: if (count_reg == 4'd0) state_next = WB;
      WB:      state_next = run ? FETCH : IDLE;
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode; operation codes are only driven after DECODE
  always_comb begin
    pcmuxctl  = '0;
    pcnextctl = 1'b0;
    instrre   = 1'b0;
    regre     = 1'b0;
    regwe     = 1'b0;
    aluctl    = 4'b0000;
    mulctl    = 2'b00;
    ifuresctl = IW'(IFURES_ALU);
    retire    = 1'b0;
    illegal   = illegal_reg;
    case (state_reg)
      FETCH:   instrre = 1'b1;
      DECODE:  regre   = 1'b1;
      EXEC:    aluctl  = dec_aluctl;
      MULWAIT: begin
        mulctl    = dec_mulctl;
        ifuresctl = IW'(IFURES_MU);
      end
      WB: begin
        regwe     = 1'b1;
        pcnextctl = 1'b1;
        retire    = 1'b1;
        aluctl    = dec_aluctl;
        mulctl    = dec_mulctl;
        ifuresctl = dec_mul ? IW'(IFURES_MU) : IW'(IFURES_ALU);
      end
      default: ;
    endcase
  end

endmodule
